// File: rtl/truth_table_reader.sv
// Truth-table reader: steps {x,y,z} through 000..111, lets the
// function under test settle, captures s per index and reports the mask.
module truth_table_reader #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] minterms,
    output logic [3:0] count,
    output logic       is_zero,
    output logic       is_one
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [2:0] r_xyz;
    logic [3:0] r_cnt;
    logic [7:0] r_shadow;
    logic [7:0] r_minterms;
    logic [3:0] r_count;
    logic       r_busy;
    logic       r_done;
    logic       r_is_zero;
    logic       r_is_one;
    logic [3:0] w_pop;

    assign x        = r_xyz[2];
    assign y        = r_xyz[1];
    assign z        = r_xyz[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign minterms = r_minterms;
    assign count    = r_count;
    assign is_zero  = r_is_zero;
    assign is_one   = r_is_one;

    // Number of ones in the mask collected during the current sweep
    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'b000, r_shadow[i]};
        end
    end

    // Sweep FSM: settle each index, capture s, publish results once at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_xyz      <= 3'd0;
            r_cnt      <= 4'd0;
            r_shadow   <= 8'h00;
            r_minterms <= 8'h00;
            r_count    <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_is_zero  <= 1'b1;
            r_is_one   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_xyz <= 3'd0;
                    if (start) begin
                        r_idx   <= 3'd0;
                        r_cnt   <= LP_SETTLE;
                        r_busy  <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_shadow[r_idx] <= s;
                    if (r_idx != 3'd7) begin
                        r_idx   <= r_idx + 3'd1;
                        r_xyz   <= r_idx + 3'd1;
                        r_cnt   <= LP_SETTLE;
                        r_state <= S_SETTLE;
                    end else begin
                        r_xyz   <= 3'd0;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_minterms <= r_shadow;
                    r_count    <= w_pop;
                    r_is_zero  <= (r_shadow == 8'h00);
                    r_is_one   <= (r_shadow == 8'hFF);
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_idx      <= 3'd0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_reader.sv
// Bench for truth_table_reader: two instances (SETTLE=1 and SETTLE=3),
// expected sweep results queued at start and compared on done.
module tb_truth_table_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic       s1, s3;
    logic       x1, y1, z1, busy1, done1, zr1, on1;
    logic       x3, y3, z3, busy3, done3, zr3, on3;
    logic [7:0] mt1, mt3;
    logic [3:0] cnt1, cnt3;

    int fsel1 = 0;
    int fsel3 = 4;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic [7:0] last1 = 8'h00;
    logic [7:0] last3 = 8'h00;

    typedef struct {
        logic [7:0] mt;
        int         cnt;
        logic       zr;
        logic       on;
        int         at;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    truth_table_reader #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s(s1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
        .minterms(mt1), .count(cnt1), .is_zero(zr1), .is_one(on1)
    );

    truth_table_reader #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .s(s3),
        .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
        .minterms(mt3), .count(cnt3), .is_zero(zr3), .is_one(on3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // functions under test: 0 x^y, 1 ~x&y&z, 2 const 0, 3 const 1, 4 x&~y
    function automatic logic fn(int sel, logic [2:0] v);
        case (sel)
            0: return v[2] ^ v[1];
            1: return ~v[2] & v[1] & v[0];
            2: return 1'b0;
            3: return 1'b1;
            default: return v[2] & ~v[1];
        endcase
    endfunction

    always_comb s1 = fn(fsel1, {x1, y1, z1});
    always_comb s3 = fn(fsel3, {x3, y3, z3});

    function automatic exp_t model(int sel);
        exp_t e;
        logic [2:0] v;
        e.mt = 8'h00;
        e.cnt = 0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            e.mt[i] = fn(sel, v);
            if (e.mt[i]) e.cnt++;
        end
        e.zr = (e.mt == 8'h00);
        e.on = (e.mt == 8'hFF);
        e.at = 0;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_done(string p, exp_t e, logic [7:0] mt,
                            logic [3:0] cn, logic zr, logic on,
                            logic bz, logic [2:0] v);
        chk({p, "_mt"}, mt, e.mt);
        chk({p, "_cnt"}, cn, e.cnt);
        chk({p, "_zero"}, zr, e.zr);
        chk({p, "_one"}, on, e.on);
        chk({p, "_at"}, cyc, e.at);
        chk({p, "_busy"}, bz, 0);
        chk({p, "_xyz"}, v, 0);
    endtask

    // done monitors: pop the expected result, flag any unexpected pulse
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) chk("d1_spur", done1, 0);
            else chk_done("d1", q1.pop_front(), mt1, cnt1, zr1, on1,
                          busy1, {x1, y1, z1});
        end
    end

    always @(negedge clk) begin
        if (rst_n && done3) begin
            if (q3.size() == 0) chk("d3_spur", done3, 0);
            else chk_done("d3", q3.pop_front(), mt3, cnt3, zr3, on3,
                          busy3, {x3, y3, z3});
        end
    end

    // one sweep; call at a negedge with the DUT idle; returns in the done cycle
    task automatic sweep(int which, int sel, int settle, int p1, int p2);
        exp_t e;
        int n;
        bit seen;
        logic [2:0] v;
        n = 8 * (settle + 1);
        e = model(sel);
        e.at = cyc + 1 + n + 1;
        if (which == 1) begin
            fsel1 = sel;
            q1.push_back(e);
            start1 = 1'b1;
        end else begin
            fsel3 = sel;
            q3.push_back(e);
            start3 = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k <= n; k++) begin
            start1 = (which == 1) && (k == p1 || k == p2);
            start3 = 1'b0;
            v = (which == 1) ? {x1, y1, z1} : {x3, y3, z3};
            if (k < n) chk("idx", v, k / (settle + 1));
            chk("busy", (which == 1) ? busy1 : busy3, 1);
            chk("hold", (which == 1) ? mt1 : mt3,
                (which == 1) ? last1 : last3);
            if (k < n) @(negedge clk);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            if ((which == 1) ? done1 : done3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (which == 1) last1 = e.mt;
        else last3 = e.mt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_xyz", {x1, y1, z1}, 0);
        chk("rst_mt", mt1, 8'h00);
        chk("rst_cnt", cnt1, 0);
        chk("rst_zero", zr1, 1);
        chk("rst_one", on1, 0);
        chk("rst_busy3", busy3, 0);
        chk("rst_mt3", mt3, 8'h00);
        chk("rst_zero3", zr3, 1);
        rst_n = 1'b1;

        sweep(1, 0, 1, -1, -1);
        sweep(1, 1, 1, -1, -1);
        sweep(1, 2, 1, -1, -1);
        sweep(1, 3, 1, -1, -1);
        repeat (3) @(negedge clk);

        sweep(1, 0, 1, 5, 16);
        @(negedge clk);
        chk("no_restart", busy1, 0);
        repeat (2) @(negedge clk);

        sweep(3, 4, 3, -1, -1);
        repeat (2) @(negedge clk);

        fsel1 = 4;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ab_busy", busy1, 0);
        chk("ab_xyz", {x1, y1, z1}, 0);
        chk("ab_done", done1, 0);
        chk("ab_mt", mt1, 8'h00);
        chk("ab_zero", zr1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        last1 = 8'h00;
        last3 = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("ab_idle", {busy1, mt1}, 0);
        end

        sweep(1, 4, 1, -1, -1);
        sweep(1, 1, 1, -1, -1);
        repeat (4) @(negedge clk);
        chk("q1_left", q1.size(), 0);
        chk("q3_left", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_reader.md
TRUTH_TABLE_READER -- requirements
Module: truth_table_reader

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of clock cycles inputs are held stable before the response is sampled (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a full truth-table sweep; sampled only in IDLE.
REQ-005 SHALL have port s  input  1  response of the combinational function under test.
REQ-006 SHALL have ports x, y, z  output  1 each  stimulus driven to the function under test (x MSB).
REQ-007 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking sweep completion.
REQ-009 SHALL have port minterms  output  8  bit i = captured s for index i = {x,y,z}.
REQ-010 SHALL have port count  output  4  number of ones in minterms (0..8).
REQ-011 SHALL have ports is_zero, is_one  output  1 each  minterms == 8'h00 / minterms == 8'hFF.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, CAPTURE, FINISH, all outputs registered.
REQ-013 SHALL leave IDLE only when start=1 at a rising edge: idx<=0, {x,y,z}<=3'b000, settle counter<=SETTLE, next state SETTLE.
REQ-014 SHALL remain in SETTLE for exactly SETTLE cycles with {x,y,z} stable, then enter CAPTURE.
REQ-015 SHALL in CAPTURE store s into shadow bit idx; if idx<7: idx<=idx+1, {x,y,z}<=idx+1, reload counter, return to SETTLE; if idx==7: go to FINISH.
REQ-016 SHALL visit indices in ascending order 0..7, each for exactly SETTLE+1 cycles.
REQ-017 SHALL in FINISH load minterms<=shadow, count<=popcount(shadow), is_zero/is_one accordingly, and assert done for exactly one cycle, then return to IDLE.
REQ-018 SHALL assert done during the cycle following the 8*(SETTLE+1)+1-th rising edge after the edge that accepted start (SETTLE=1: 17 edges).
REQ-019 SHALL hold busy=1 from the edge accepting start through the FINISH cycle inclusive; busy=0 in IDLE.
REQ-020 SHALL ignore start whenever the state is not IDLE (including the FINISH cycle); no restart, no queuing.
REQ-021 SHALL keep minterms, count, is_zero and is_one unchanged from one done pulse until the next; never update them mid-sweep.
REQ-022 SHALL drive {x,y,z}=3'b000 in IDLE.
REQ-023 SHALL accept start in the cycle immediately after FINISH (back-to-back sweeps, no dead cycle beyond FINISH).

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, idx=0, {x,y,z}=000, busy=0, done=0, minterms=8'h00, count=0, is_zero=1, is_one=0, independent of clk.
REQ-025 SHALL on reset mid-sweep discard partial shadow contents, emit no done, and not update minterms.
REQ-026 SHALL act on the first rising edge after rst_n deasserts (start sampled normally).

Verification
REQ-027 SHALL cover: s = x XOR y, SETTLE=1, pulse start -> done at edge 17, minterms=8'h3C, count=4, is_zero=0, is_one=0.
REQ-028 SHALL cover: s = ~x & y & z -> minterms=8'h08, count=1; then s tied 0 -> 8'h00, count=0, is_zero=1; s tied 1 -> 8'hFF, count=8, is_one=1.
REQ-029 SHALL cover: SETTLE=3, s = x & ~y -> each index held 4 cycles, done at edge 33, minterms=8'h30, count=2.
REQ-030 SHALL cover: start re-pulsed at cycles 5 and 16 (during FINISH, SETTLE=1) -> ignored, single done, busy low the cycle after FINISH.
REQ-031 SHALL cover: rst_n low at cycle 9 of a sweep -> immediate busy=0, x,y,z=000, minterms keeps reset 8'h00, no done; fresh sweep after release yields correct mask.
